// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer: owns the PC, picks the next fetch address, sequences fetch and flush.
// Optional compressed-instruction support is enabled by defining PC_SEQ_RVC_EN.
module pc_seq_ctrl #(
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          INSTR_BYTES  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        fetch_ready,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    input  logic        jump,
    input  logic [63:0] jump_target,
    input  logic        trap_req,
    input  logic [63:0] trap_vec,
`ifdef PC_SEQ_RVC_EN
    input  logic        is_compressed,
`endif
    output logic [63:0] pc,
    output logic        fetch_req,
    output logic        flush,
    output logic        misalign_trap,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } state_t;

`ifdef PC_SEQ_RVC_EN
    localparam logic [63:0] AMASK = ~64'h1;
`else
    localparam logic [63:0] AMASK = ~64'h3;
`endif
    localparam logic [3:0] FC = 4'(FLUSH_CYCLES);

    state_t      state, state_d;
    logic [63:0] pc_d;
    logic [3:0]  cnt, cnt_d;
    logic        mis_d;
    logic [63:0] tv_al;
    logic [63:0] tgt;
    logic [63:0] inc;

`ifdef PC_SEQ_RVC_EN
    assign inc = is_compressed ? 64'd2 : 64'(INSTR_BYTES);
`else
    assign inc = 64'(INSTR_BYTES);
`endif

    always_comb begin
        state_d = state;
        pc_d    = pc;
        cnt_d   = cnt;
        mis_d   = 1'b0;
        tv_al   = trap_vec & AMASK;
        tgt     = jump ? jump_target : branch_target;
        unique case (state)
            BOOT: state_d = RUN;
            RUN, STALL: begin
                if (trap_req) begin
                    pc_d    = tv_al;
                    cnt_d   = FC;
                    state_d = FLUSH;
                end else if (jump || branch_taken) begin
                    cnt_d   = FC;
                    state_d = FLUSH;
                    // misaligned targets divert to the trap handler
                    if (|(tgt & ~AMASK)) begin
                        pc_d  = tv_al;
                        mis_d = 1'b1;
                    end else begin
                        pc_d = tgt;
                    end
                end else if (stall || !fetch_ready) begin
                    state_d = STALL;
                end else begin
                    state_d = RUN;
                    if (state == RUN) pc_d = pc + inc;
                end
            end
            FLUSH: begin
                if (trap_req) begin
                    pc_d  = tv_al;
                    cnt_d = FC;
                end else if (cnt <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BOOT;
            pc            <= RESET_VECTOR;
            cnt           <= 4'd0;
            misalign_trap <= 1'b0;
        end else begin
            state         <= state_d;
            pc            <= pc_d;
            cnt           <= cnt_d;
            misalign_trap <= mis_d;
        end
    end

    assign fetch_req = (state == RUN) || (state == STALL);
    assign flush     = (state == FLUSH);
    assign state_o   = state;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl; expected outputs queued per cycle and checked after each edge.
module tb_pc_seq_ctrl;

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic        clk = 1'b0;
    logic        rst, stall, fetch_ready, branch_taken, jump, trap_req;
    logic [63:0] branch_target, jump_target, trap_vec;
    logic [63:0] pc;
    logic        fetch_req, flush, misalign_trap;
    logic [1:0]  state_o;

    typedef struct {
        logic [63:0] pc;
        logic [1:0]  st;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pc_seq_ctrl #(
        .RESET_VECTOR(64'h1000),
        .FLUSH_CYCLES(2),
        .INSTR_BYTES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .fetch_ready(fetch_ready),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .jump(jump),
        .jump_target(jump_target),
        .trap_req(trap_req),
        .trap_vec(trap_vec),
`ifdef PC_SEQ_RVC_EN
        .is_compressed(1'b0),
`endif
        .pc(pc),
        .fetch_req(fetch_req),
        .flush(flush),
        .misalign_trap(misalign_trap),
        .state_o(state_o)
    );

    // ctl = {rst, stall, fetch_ready, branch_taken, jump, trap_req}
    task automatic cyc(input string tag, input logic [5:0] ctl,
                       input logic [63:0] tgt, input logic [63:0] epc,
                       input logic [1:0] est, input logic emis);
        exp_t e;
        logic efr, efl;
        {rst, stall, fetch_ready, branch_taken, jump, trap_req} = ctl;
        branch_target = tgt;
        jump_target   = tgt;
        e.pc = epc; e.st = est; e.mis = emis;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = q.pop_front();
            efr = (e.st == S_RUN) || (e.st == S_STALL);
            efl = (e.st == S_FLUSH);
            vectors++;
            assert (pc === e.pc) else begin
                miscompares++;
                $error("FAIL %s pc obs=%h exp=%h", tag, pc, e.pc);
            end
            vectors++;
            assert (state_o === e.st) else begin
                miscompares++;
                $error("FAIL %s state obs=%0d exp=%0d", tag, state_o, e.st);
            end
            vectors++;
            assert (fetch_req === efr) else begin
                miscompares++;
                $error("FAIL %s fetch_req obs=%b exp=%b", tag, fetch_req, efr);
            end
            vectors++;
            assert (flush === efl) else begin
                miscompares++;
                $error("FAIL %s flush obs=%b exp=%b", tag, flush, efl);
            end
            vectors++;
            assert (misalign_trap === e.mis) else begin
                miscompares++;
                $error("FAIL %s misalign obs=%b exp=%b", tag, misalign_trap, e.mis);
            end
        end
    endtask

    initial begin
        trap_vec = 64'h8003;
        // reset and sequential fetch
        cyc("rst0",   6'b100000, 64'h0, 64'h1000, S_BOOT,  1'b0);
        cyc("rst1",   6'b100000, 64'h0, 64'h1000, S_BOOT,  1'b0);
        cyc("run0",   6'b001000, 64'h0, 64'h1000, S_RUN,   1'b0);
        cyc("run1",   6'b001000, 64'h0, 64'h1004, S_RUN,   1'b0);
        cyc("run2",   6'b001000, 64'h0, 64'h1008, S_RUN,   1'b0);
        // stall holds PC
        cyc("stl0",   6'b011000, 64'h0, 64'h1008, S_STALL, 1'b0);
        cyc("stl1",   6'b011000, 64'h0, 64'h1008, S_STALL, 1'b0);
        cyc("stl2",   6'b011000, 64'h0, 64'h1008, S_STALL, 1'b0);
        cyc("rel",    6'b001000, 64'h0, 64'h1008, S_RUN,   1'b0);
        cyc("rel1",   6'b001000, 64'h0, 64'h100C, S_RUN,   1'b0);
        cyc("nrdy",   6'b000000, 64'h0, 64'h100C, S_STALL, 1'b0);
        cyc("rdy",    6'b001000, 64'h0, 64'h100C, S_RUN,   1'b0);
        cyc("rdy1",   6'b001000, 64'h0, 64'h1010, S_RUN,   1'b0);
        // taken branch
        cyc("br",     6'b001100, 64'h2000, 64'h2000, S_FLUSH, 1'b0);
        cyc("brf1",   6'b001000, 64'h0,    64'h2000, S_FLUSH, 1'b0);
        cyc("brrun",  6'b001000, 64'h0,    64'h2000, S_RUN,   1'b0);
        cyc("brseq",  6'b001000, 64'h0,    64'h2004, S_RUN,   1'b0);
        // priority: trap over jump and branch
        cyc("pri",    6'b001111, 64'h3002, 64'h8000, S_FLUSH, 1'b0);
        cyc("prif",   6'b001000, 64'h0,    64'h8000, S_FLUSH, 1'b0);
        cyc("prirun", 6'b001000, 64'h0,    64'h8000, S_RUN,   1'b0);
        // misaligned jump
        cyc("mis",    6'b001010, 64'h3002, 64'h8000, S_FLUSH, 1'b1);
        cyc("misf",   6'b001000, 64'h0,    64'h8000, S_FLUSH, 1'b0);
        cyc("misrun", 6'b001000, 64'h0,    64'h8000, S_RUN,   1'b0);
        // branch ignored in flush window, stall ignored too
        cyc("fb0",    6'b001100, 64'h2000, 64'h2000, S_FLUSH, 1'b0);
        cyc("fbign",  6'b011100, 64'h4000, 64'h2000, S_FLUSH, 1'b0);
        cyc("fbrun",  6'b001000, 64'h0,    64'h2000, S_RUN,   1'b0);
        // trap in flush window restarts counter
        cyc("ft0",    6'b001100, 64'h2000, 64'h2000, S_FLUSH, 1'b0);
        cyc("ftrap",  6'b001001, 64'h0,    64'h8000, S_FLUSH, 1'b0);
        cyc("ftx1",   6'b001000, 64'h0,    64'h8000, S_FLUSH, 1'b0);
        cyc("ftx2",   6'b001000, 64'h0,    64'h8000, S_RUN,   1'b0);
        // redirect honoured from STALL
        cyc("sr0",    6'b011000, 64'h0,    64'h8000, S_STALL, 1'b0);
        cyc("srbr",   6'b011100, 64'h2100, 64'h2100, S_FLUSH, 1'b0);
        cyc("srf",    6'b001000, 64'h0,    64'h2100, S_FLUSH, 1'b0);
        cyc("srrun",  6'b001000, 64'h0,    64'h2100, S_RUN,   1'b0);
        // wrap at top of address space
        cyc("wj",     6'b001010, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, S_FLUSH, 1'b0);
        cyc("wf",     6'b001000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, S_FLUSH, 1'b0);
        cyc("wrun",   6'b001000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, S_RUN,   1'b0);
        cyc("wrap",   6'b001000, 64'h0, 64'h0,                   S_RUN,   1'b0);
        // reset mid-flush
        cyc("mrbr",   6'b001100, 64'h2000, 64'h2000, S_FLUSH, 1'b0);
        cyc("mrst",   6'b101000, 64'h0,    64'h1000, S_BOOT,  1'b0);
        cyc("mrrun",  6'b001000, 64'h0,    64'h1000, S_RUN,   1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
Next-PC sequencer for the 64-bit fetch stage. It owns the architectural PC register and chooses the next address from these sources:
- sequential increment
- branch target
- jump target
- trap vector

It also sequences the fetch handshake and generates pipeline flush pulses on redirects. It sits between the branch/trap resolution logic and the instruction-memory fetch port, and replaces a bare PC register plus external next-address mux.

Parameters:
RESET_VECTOR, 64'h0, PC value loaded on reset.
FLUSH_CYCLES, 2, cycles flush stays high after any redirect; legal range 1..15.
INSTR_BYTES, 4, sequential increment in bytes.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset, sampled on posedge clk.
stall  input  1  downstream hazard; hold PC.
fetch_ready  input  1  imem accepts the fetch address this cycle.
branch_taken  input  1  resolved taken branch, single-cycle pulse.
branch_target  input  64  branch destination.
jump  input  1  jal/jalr resolved, single-cycle pulse.
jump_target  input  64  jump destination.
trap_req  input  1  exception/interrupt request.
trap_vec  input  64  trap handler base (mtvec).
pc  output  64  current PC (registered).
fetch_req  output  1  fetch address pc is valid.
flush  output  1  kill younger in-flight instructions.
misalign_trap  output  1  one-cycle pulse: redirect target was misaligned.
state_o  output  2  FSM state (BOOT=0, RUN=1, STALL=2, FLUSH=3), debug.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high on rst; no asynchronous reset path.
- Reset values: pc=RESET_VECTOR, state=BOOT, fetch_req=0, flush=0, misalign_trap=0, flush counter=0. rst overrides every other input in the same cycle, including mid-FLUSH or mid-STALL.
- All outputs are registered, or decoded purely from registered state. fetch_req=1 only in RUN and STALL.
- Redirect priority, evaluated in RUN and STALL: trap_req > jump > branch_taken > (stall | !fetch_ready) > sequential.
- Alignment: a target is misaligned if bits[1:0]!=0.
- BOOT: lasts one cycle, then goes to RUN. pc holds.
- RUN:
  - trap_req: pc<=trap_vec with bits[1:0] forced to 0; go to FLUSH.
  - jump or branch_taken with an aligned target: pc<=target; go to FLUSH.
  - jump or branch_taken with a misaligned target: pc<=aligned trap_vec; misalign_trap=1 for one cycle; go to FLUSH.
  - stall=1 or fetch_ready=0: pc holds; go to STALL.
  - otherwise: pc<=pc+INSTR_BYTES, modulo 2^64. 64'hFFFF_FFFF_FFFF_FFFC wraps to 0 with no flag.
- STALL:
  - pc holds.
  - Redirects are honoured exactly as in RUN.
  - When stall=0 and fetch_ready=1: go to RUN without incrementing that cycle. The held address is then fetched in RUN.
- FLUSH:
  - flush=1 and fetch_req=0 for exactly FLUSH_CYCLES cycles; the counter loads FLUSH_CYCLES on entry.
  - jump/branch_taken are ignored.
  - trap_req reloads pc with the aligned trap_vec and restarts the counter.
  - stall is ignored.
  - When the counter expires, go to RUN.
- Timing:
  - Redirect latency: event at cycle N; pc holds the target and flush=1 from cycle N+1; fetch_req=1 again at cycle N+1+FLUSH_CYCLES.
  - Simultaneous branch_taken and jump: jump wins.
  - Simultaneous trap_req and any redirect: trap wins and misalign_trap stays 0.

Optional Feature:
Macro PC_SEQ_RVC_EN.
- Defined:
  - Adds input is_compressed (1 bit). The sequential increment is 2 when is_compressed=1, else INSTR_BYTES.
  - A target is misaligned only if bit[0]=1; trap_vec bit[0] is forced to 0.
- Undefined:
  - The is_compressed port does not exist.
  - Increment is always INSTR_BYTES; 4-byte alignment applies.

Test Plan:
1. Reset and sequential fetch: rst high 2 cycles, RESET_VECTOR=64'h1000, then 3 free cycles.
   -> pc=1000 during BOOT; fetch_req=1 from the next cycle; pc then 1000, 1004, 1008, 100C.
2. Stall: at pc=1008, stall=1 for 3 cycles.
   -> pc holds 1008 and state=STALL; after release, 1008 is fetched in RUN, then 100C.
3. Taken branch: branch_taken=1, target=64'h2000.
   -> next cycle pc=2000 and flush=1 for 2 cycles with fetch_req=0; then pc=2000 fetched, then 2004.
4. Priority and misalignment:
   - trap_req, jump and branch_taken in the same cycle, trap_vec=64'h8003 -> pc=8000, misalign_trap=0.
   - jump alone with jump_target=64'h3002 -> pc=trap_vec aligned, misalign_trap pulses once.
5. Redirect during FLUSH:
   - branch_taken in the flush window -> ignored.
   - trap_req in the window -> pc=aligned trap_vec and flush extended a full FLUSH_CYCLES.
6. Wrap and mid-operation reset:
   - pc=64'hFFFF_FFFF_FFFF_FFFC, free cycle -> pc=0.
   - rst asserted mid-FLUSH -> next cycle pc=RESET_VECTOR, flush=0, state=BOOT.
